// File: rtl/shift_sequencer_pkg.sv
// Shared ALU package for the shift sequencer.
// Holds the state encoding, direction and mode constants, and the effective step count helper.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic LEFT    = 1'b0;
  localparam logic RIGHT   = 1'b1;
  localparam logic LOGICAL = 1'b0;
  localparam logic ROTATE  = 1'b1;

  // A rotate by four is the identity, and a logical shift by four or more
  // already clears a 4-bit operand, so neither ever needs more than four steps.
  function automatic logic [2:0] effCount(input logic [2:0] amt, input logic rot);
    if (rot == ROTATE)
      return {1'b0, amt[1:0]};
    else if (amt >= 3'd4)
      return 3'd4;
    else
      return amt;
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-position shift/rotate of a 4-bit value.
// The vacated bit takes the bit shifted out when rotating, otherwise zero.
module shift_step_unit
  import shift_sequencer_pkg::*;
(
  input  logic [3:0] d,
  input  logic       rot,
  input  logic       dir,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (dir == LEFT)
      q = {d[2:0], (rot == ROTATE) ? d[3] : 1'b0};
    else
      q = {(rot == ROTATE) ? d[0] : 1'b0, d[3:1]};
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate controller: captures an operand and applies one
// single-position step per clock until the effective amount is reached.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [2:0] amt,
  input  logic       rot,
  input  logic       dir,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       zero
);

  state_t     state, nextState;
  logic [3:0] data;
  logic [2:0] count;
  logic       rotReg;
  logic       dirReg;
  logic [3:0] stepOut;
  logic [2:0] eff;

  assign eff = effCount(amt, rot);

  shift_step_unit stepUnit (
    .d   (data),
    .rot (rotReg),
    .dir (dirReg),
    .q   (stepOut)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start)
          nextState = (eff == 3'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == 3'd1)
          nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The last step is written straight into result so that DONE is entered
  // on the same edge that applies the final shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= 4'd0;
      count  <= 3'd0;
      rotReg <= LOGICAL;
      dirReg <= LEFT;
      result <= 4'd0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data   <= a;
            count  <= eff;
            rotReg <= rot;
            dirReg <= dir;
            if (eff == 3'd0) begin
              result <= a;
              zero   <= (a == 4'd0);
            end
          end
        end
        SHIFT: begin
          data  <= stepOut;
          count <= count - 3'd1;
          if (count == 3'd1) begin
            result <= stepOut;
            zero   <= (stepOut == 4'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// operations checked against a step-by-step arithmetic reference model.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [2:0] amt;
  logic       rot;
  logic       dir;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       zero;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .amt    (amt),
    .rot    (rot),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One literal single-position move, written as plain arithmetic.
  function automatic logic [3:0] stepModel(input logic [3:0] d, input logic r, input logic rightDir);
    int v;
    v = int'(d);
    if (!rightDir)
      v = r ? (((v * 2) + (v / 8)) % 16) : ((v * 2) % 16);
    else
      v = r ? ((v / 2) + ((v % 2) * 8)) : (v / 2);
    return v[3:0];
  endfunction

  task automatic applyStimulus(input logic [3:0] opA, input logic [2:0] opAmt,
                               input logic opRot, input logic opDir, input bit disturb);
    logic [3:0] expRes;
    logic [7:0] expLat;
    logic [7:0] lat;
    bit         seen;
    expRes = opA;
    for (int i = 0; i < int'(opAmt); i++) expRes = stepModel(expRes, opRot, opDir);
    if (opRot) expLat = 8'(opAmt % 3'd4) + 8'd1;
    else       expLat = ((opAmt > 3'd4) ? 8'd4 : 8'(opAmt)) + 8'd1;

    @(negedge clk);
    a = opA; amt = opAmt; rot = opRot; dir = opDir; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom); amt = 3'($urandom); rot = 1'($urandom); dir = 1'($urandom);
    lat  = 8'd1;
    seen = 1'b0;
    while (!seen && lat <= 8'd12) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        checkOutput("busyDuringOp", {7'd0, busy}, 8'd1);
        if (disturb && lat == 8'd1) begin
          a = 4'd0; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        lat++;
      end
    end
    if (!seen) begin
      checkOutput("doneTimeout", 8'd0, 8'd1);
    end else begin
      checkOutput("latency", lat, expLat);
      checkOutput("busyAtDone", {7'd0, busy}, 8'd1);
      checkOutput("result", {4'd0, result}, {4'd0, expRes});
      checkOutput("zero", {7'd0, zero}, {7'd0, (expRes == 4'd0)});
    end
    @(negedge clk);
    checkOutput("donePulse", {7'd0, done}, 8'd0);
    checkOutput("busyAfter", {7'd0, busy}, 8'd0);
    checkOutput("resultHeld", {4'd0, result}, {4'd0, expRes});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 4'd0; amt = 3'd0; rot = 1'b0; dir = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", {7'd0, busy}, 8'd0);
    checkOutput("resetDone", {7'd0, done}, 8'd0);
    checkOutput("resetResult", {4'd0, result}, 8'd0);
    checkOutput("resetZero", {7'd0, zero}, 8'd1);
    rst = 1'b0;

    applyStimulus(4'b1001, 3'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1011, 3'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0110, 3'd5, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1111, 3'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 3'd3, 1'b1, 1'b0, 1'b1);

    // Reset mid-SHIFT aborts without a done pulse.
    @(negedge clk);
    a = 4'b1001; amt = 3'd3; rot = 1'b1; dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", {7'd0, busy}, 8'd0);
    checkOutput("abortResult", {4'd0, result}, 8'd0);
    checkOutput("abortZero", {7'd0, zero}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("abortNoDone", {7'd0, done}, 8'd0);
      @(negedge clk);
    end

    // Reset wins over start on the same edge.
    a = 4'd5; amt = 3'd2; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("resetBeatsStart", {7'd0, busy}, 8'd0);

    // Start held high through DONE is taken again at the next idle edge.
    @(negedge clk);
    a = 4'd5; amt = 3'd0; rot = 1'b0; start = 1'b1;
    @(negedge clk);
    checkOutput("heldFirstDone", {7'd0, done}, 8'd1);
    checkOutput("heldFirstResult", {4'd0, result}, 8'd5);
    @(negedge clk);
    checkOutput("heldIdleBusy", {7'd0, busy}, 8'd0);
    a = 4'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("heldSecondDone", {7'd0, done}, 8'd1);
    checkOutput("heldSecondResult", {4'd0, result}, 8'd3);

    for (int n = 0; n < 40; n++)
      applyStimulus(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
